mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multicycle successor to the single-cycle MIPS control decoder.
- A Moore FSM sequences each instruction over 3-5 states: FETCH, DECODE, then execute/memory/writeback.
- Drives the shared-memory multicycle datapath (PC, IR, A/B, ALUOut, MDR registers).
- Adds three capabilities:
  - memory wait-state handshake;
  - jr handling;
  - sticky illegal-opcode trap with a retired-instruction counter.

Parameters:
- MEM_WAIT_EN, 1, 1 = honour mem_ready in memory states; 0 = treat mem_ready as constant 1.
- CNT_W, 32, width of the retired-instruction counter.
- ALUOP_W, 3, ALUOp width. Encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 funct-decoded.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory completes the access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  conditional PC load; datapath qualifies it with zero XOR BranchNe.
- BranchNe  out  1  invert the branch condition (bne).
- PCSource  out  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target, 11 register A.
- IorD  out  1  memory address select: 0 PC, 1 ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load IR.
- MemToReg  out  1  register write-data select: 1 MDR, 0 ALUOut.
- RegDst  out  2  destination register select: 00 rt, 01 rd, 10 $31.
- RegWrite  out  1  register-file write strobe.
- Jal  out  1  register write data = PC.
- ALUSrcA  out  1  ALU A select: 0 PC, 1 A.
- ALUSrcB  out  3  ALU B select: 000 B, 001 const 4, 010 sign-extended imm, 011 sign-extended imm<<2, 100 zero-extended imm, 101 imm<<16.
- ALUOp  out  ALUOP_W  ALU operation.
- instr_done  out  1  one-cycle pulse in the last state of each instruction.
- retired  out  CNT_W  count of retired instructions.
- illegal  out  1  sticky trap flag.

Behaviour:
- Reset:
  - While rst_n=0, every write/strobe output is forced to 0: PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, instr_done.
  - At the edge: state<=FETCH, retired<=0, illegal<=0.
  - Reset asserted mid-instruction aborts it; no partial write escapes.
- Defaults: every output is 0 unless listed for the current state.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=001, ALUOp=000, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE when ready.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=011, ALUOp=000 (branch target to ALUOut).
  - Dispatch:
    - op 0 & funct 8 -> JR; op 0 otherwise -> REXEC.
    - op 4/5 -> BRANCH.
    - op 8,10,11,12,13,14,15 -> IEXEC.
    - op 35/43 -> MEMADR.
    - op 2 -> JUMP; op 3 -> JAL.
    - any other opcode -> TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=010, ALUOp=000; next is MEMRD (op 35) or MEMWR (op 43).
- MEMRD: MemRead=1, IorD=1; waits on mem_ready, then MEMWB.
- MEMWB: RegDst=00, MemToReg=1, RegWrite=1, instr_done=1; next FETCH.
- MEMWR: MemWrite=1, IorD=1.
  - MemWrite holds while waiting for mem_ready.
  - instr_done=mem_ready; goes to FETCH when ready.
- REXEC: ALUSrcA=1, ALUSrcB=000, ALUOp=110; next RWB.
- RWB: RegDst=01, RegWrite=1, instr_done=1; next FETCH.
- IEXEC:
  - ALUSrcA=1.
  - Per opcode: op 8 -> ALUOp 000, ALUSrcB 010; op 10/11 -> 101, 010; op 12 -> 010, 100; op 13 -> 011, 100; op 14 -> 100, 100; op 15 -> 000, 101.
  - Next IWB.
- IWB: RegDst=00, MemToReg=0, RegWrite=1, instr_done=1; next FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=000, ALUOp=001, PCWriteCond=1, PCSource=01, instr_done=1.
  - BranchNe=(opcode==5).
  - Next FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1; next FETCH.
- JAL:
  - Outputs: PCWrite=1, PCSource=10, RegDst=10, RegWrite=1, Jal=1, instr_done=1.
  - The register file captures the current PC (already PC+4) at the same edge the PC loads the target.
  - Next FETCH.
- JR: PCWrite=1, PCSource=11, instr_done=1; next FETCH.
- TRAP:
  - illegal<=1; all strobes 0.
  - Absorbing: only reset leaves TRAP.
- Counter:
  - retired increments at every edge where instr_done=1.
  - Wraps modulo 2^CNT_W.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- MEM_WAIT_EN=0: FETCH, MEMRD and MEMWR each last exactly one cycle.
- Latency in cycles with no wait states: lw 5; sw, R-type and I-type 4; beq/bne, j, jal and jr 3.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants and FUNCT_JR=8;
  - ALUOp codes, ALUSrcB codes, PCSource codes, RegDst codes;
  - the state enumeration (4-bit).
- One combinational sub-module, mc_imm_decode: opcode -> {ALUOp, ALUSrcB} for IEXEC.

Test Plan:
- Reset: rst_n=0 for 2 cycles with mem_ready=1 -> all strobes 0, retired=0, illegal=0; first cycle after release is FETCH with MemRead=1.
- lw (op 35) with MEM_WAIT_EN=1 and mem_ready low for 2 cycles in MEMRD -> MemRead/IorD held for 3 cycles; MEMWB asserts RegWrite=1, MemToReg=1; retired 0->1; total 7 cycles.
- bne (op 5) -> BRANCH shows PCWriteCond=1, BranchNe=1, PCSource=01, ALUOp=001; beq repeats it with BranchNe=0; 3 cycles each.
- jal (op 3) -> JAL shows PCWrite=1, RegWrite=1, RegDst=10, Jal=1, PCSource=10; jr (op 0, funct 8) -> PCSource=11 with no RegWrite.
- andi (op 12) and lui (op 15) -> IEXEC shows ALUSrcB=100/ALUOp=010, then 101/000; IWB shows RegDst=00.
- Illegal opcode 63 -> TRAP, illegal=1 held for 10 cycles with all strobes 0; asserting rst_n=0 clears illegal and returns to FETCH; a 4-bit counter (CNT_W=4) wraps from 15 to 0 on the 16th retirement.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Package  : mips_ctrl_pkg
// Brief    : Shared opcodes, datapath select codes and FSM states for mc_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] FUNCT_JR = 6'd8;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_AND   = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_XOR   = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;
    localparam logic [2:0] ALUOP_FUNCT = 3'b110;

    localparam logic [2:0] ALUSRCB_B        = 3'b000;
    localparam logic [2:0] ALUSRCB_FOUR     = 3'b001;
    localparam logic [2:0] ALUSRCB_SEXT     = 3'b010;
    localparam logic [2:0] ALUSRCB_SEXT_SH2 = 3'b011;
    localparam logic [2:0] ALUSRCB_ZEXT     = 3'b100;
    localparam logic [2:0] ALUSRCB_LUI      = 3'b101;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REXEC  = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_IEXEC  = 4'd8;
    localparam logic [3:0] S_IWB    = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;
    localparam logic [3:0] S_JR     = 4'd13;
    localparam logic [3:0] S_TRAP   = 4'd14;

    // DECODE dispatch; anything unrecognised lands in the absorbing trap.
    function automatic logic [3:0] dispatch(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] st;
        st = S_TRAP;
        case (op)
            OP_RTYPE:                 st = (fn == FUNCT_JR) ? S_JR : S_REXEC;
            OP_BEQ, OP_BNE:           st = S_BRANCH;
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI:  st = S_IEXEC;
            OP_LW, OP_SW:             st = S_MEMADR;
            OP_J:                     st = S_JUMP;
            OP_JAL:                   st = S_JAL;
            default:                  st = S_TRAP;
        endcase
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_imm_decode.sv
`default_nettype none
//==============================================================================
// Module   : mc_imm_decode
// Brief    : I-type opcode to {ALUOp, ALUSrcB} for the IEXEC state.
// Revision : 1.0 - initial release
//==============================================================================
module mc_imm_decode
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3
) (
    input  logic [5:0]         i_opcode,
    output logic [ALUOP_W-1:0] o_aluop,
    output logic [2:0]         o_alusrcb
);

    logic [2:0] w_aluop;

    always_comb begin
        w_aluop   = ALUOP_ADD;
        o_alusrcb = ALUSRCB_SEXT;
        case (i_opcode)
            OP_SLTI, OP_SLTIU: begin w_aluop = ALUOP_SLT; o_alusrcb = ALUSRCB_SEXT; end
            OP_ANDI:           begin w_aluop = ALUOP_AND; o_alusrcb = ALUSRCB_ZEXT; end
            OP_ORI:            begin w_aluop = ALUOP_OR;  o_alusrcb = ALUSRCB_ZEXT; end
            OP_XORI:           begin w_aluop = ALUOP_XOR; o_alusrcb = ALUSRCB_ZEXT; end
            OP_LUI:            begin w_aluop = ALUOP_ADD; o_alusrcb = ALUSRCB_LUI;  end
            default:           begin w_aluop = ALUOP_ADD; o_alusrcb = ALUSRCB_SEXT; end
        endcase
    end

    assign o_aluop = ALUOP_W'(w_aluop);

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : mc_ctrl
// Brief    : Multicycle MIPS control FSM with memory wait states, jr and trap.
// Revision : 1.0 - initial release
//==============================================================================
module mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int CNT_W       = 32,
    parameter int ALUOP_W     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic [1:0]         RegDst,
    output logic               RegWrite,
    output logic               Jal,
    output logic               ALUSrcA,
    output logic [2:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               instr_done,
    output logic [CNT_W-1:0]   retired,
    output logic               illegal
);

    logic [3:0]         r_state;
    logic [3:0]         w_next;
    logic [CNT_W-1:0]   r_retired;
    logic               r_illegal;
    logic               w_rdy;
    logic [ALUOP_W-1:0] w_imm_aluop;
    logic [2:0]         w_imm_srcb;

    assign w_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    mc_imm_decode #(.ALUOP_W(ALUOP_W)) u_imm_decode (
        .i_opcode  (opcode),
        .o_aluop   (w_imm_aluop),
        .o_alusrcb (w_imm_srcb)
    );

    always_comb begin
        w_next      = r_state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        PCSource    = PCSRC_ALU;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = REGDST_RT;
        RegWrite    = 1'b0;
        Jal         = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = ALUSRCB_B;
        ALUOp       = ALUOP_W'(ALUOP_ADD);
        instr_done  = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = ALUSRCB_FOUR;
                IRWrite = w_rdy;
                PCWrite = w_rdy;
                if (w_rdy) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = ALUSRCB_SEXT_SH2;
                w_next  = dispatch(opcode, funct);
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUSRCB_SEXT;
                w_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (w_rdy) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = w_rdy;
                if (w_rdy) w_next = S_FETCH;
            end
            S_REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_W'(ALUOP_FUNCT);
                w_next  = S_RWB;
            end
            S_RWB: begin
                RegDst     = REGDST_RD;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = w_imm_srcb;
                ALUOp   = w_imm_aluop;
                w_next  = S_IWB;
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_W'(ALUOP_SUB);
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                BranchNe    = (opcode == OP_BNE);
                instr_done  = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            // PC already holds PC+4 here, so the link value is read straight from it.
            S_JAL: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                RegDst     = REGDST_RA;
                RegWrite   = 1'b1;
                Jal        = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_JR: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_REGA;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
        // An aborted instruction must not leak a write while reset is held.
        if (!rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            instr_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (instr_done) r_retired <= r_retired + CNT_W'(1);
            if (r_state == S_TRAP) r_illegal <= 1'b1;
        end
    end

    assign retired = r_retired;
    assign illegal = r_illegal;

endmodule
`default_nettype wire
